sipo_rx_day7: RTL and testbench

//  Serial-in/parallel-out framed receiver; the deserialising counterpart of the
//  day-6 shift register.
//  - Samples a 1-bit line on each enable strobe: start bit (0), WIDTH data bits,

---
 rtl/sipo_rx_day7.sv | 109 ++++++++++
 tb/tb_sipo_rx_day7.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx_day7.sv
// Framed serial-in/parallel-out receiver.
// Start bit, WIDTH data bits, stop bit; one-word valid/ready holding register.
module sipo_rx_day7 #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sd_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             frame_err_o,
  output logic             overrun_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             accept;

  assign accept = valid_q && ready_i;

  // Frame sequencing, shifting and holding-register handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    if (accept) valid_d = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (!sd_i) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          if (MSB_FIRST) sh_d = {sh_q[WIDTH-2:0], sd_i};
          else           sh_d = {sd_i, sh_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = STOP;
        end
        STOP: begin
          // A low stop bit is an error, never a new start bit.
          state_d = IDLE;
          if (sd_i) begin
            if (!valid_q || accept) begin
              data_d  = sh_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign busy_o      = (state_q != IDLE);
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_sipo_rx_day7.sv
// Bench for sipo_rx_day7: LSB- and MSB-first receivers
// fed the same stream, checked against a frame-level model.
module tb_sipo_rx_day7;

  logic       clk = 1'b0;
  logic       reset, en, sd_i, ready_i;
  logic [3:0] data_l, data_m;
  logic       valid_l, valid_m, busy_l, busy_m;
  logic       fe_l, fe_m, ov_l, ov_m;

  int tests = 0;
  int fails = 0;

  // frame-level model of the holding register
  bit         mv;
  logic [3:0] md_l, md_m;
  bit         m_fe, m_ov;
  logic [3:0] cur_l, cur_m;

  always #5 clk = ~clk;

  sipo_rx_day7 #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .en(en), .sd_i(sd_i),
    .data_o(data_l), .valid_o(valid_l), .ready_i(ready_i),
    .busy_o(busy_l), .frame_err_o(fe_l), .overrun_o(ov_l)
  );

  sipo_rx_day7 #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .en(en), .sd_i(sd_i),
    .data_o(data_m), .valid_o(valid_m), .ready_i(ready_i),
    .busy_o(busy_m), .frame_err_o(fe_m), .overrun_o(ov_m)
  );

  // One clock with given inputs; model follows the handshake rules.
  task automatic tick(input bit s_en, input bit s_sd, input bit is_stop);
    bit ld;
    en   = s_en;
    sd_i = s_sd;
    ld   = 1'b0;
    m_fe = 1'b0;
    m_ov = 1'b0;
    if (s_en && is_stop) begin
      if (!s_sd)              m_fe = 1'b1;
      else if (!mv || ready_i) ld  = 1'b1;
      else                     m_ov = 1'b1;
    end
    if (ld) begin
      mv   = 1'b1;
      md_l = cur_l;
      md_m = cur_m;
    end else if (mv && ready_i) begin
      mv = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Send start, b[0]..b[3] in line order, then stop; one strobe per `per` clocks.
  task automatic send_frame(input logic [3:0] b, input bit stop, input int per);
    logic [5:0] line;
    cur_l = b;
    for (int i = 0; i < 4; i++) cur_m[3-i] = b[i];
    line = {stop, b, 1'b0};
    for (int k = 0; k < 6; k++) begin
      for (int g = 1; g < per; g++) tick(1'b0, line[k], 1'b0);
      tick(1'b1, line[k], k == 5);
    end
    en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b1;
    sd_i  = 1'b1;
    mv    = 1'b0;
    md_l  = '0;
    md_m  = '0;
    m_fe  = 1'b0;
    m_ov  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    en    = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({valid_l, data_l, fe_l, ov_l, busy_l} !== 8'b0) begin
      fails++;
      $display("FAIL reset_lsb got=%b want=%b",
               {valid_l, data_l, fe_l, ov_l, busy_l}, 8'b0);
    end
    tests++;
    if ({valid_m, data_m, fe_m, ov_m, busy_m} !== 8'b0) begin
      fails++;
      $display("FAIL reset_msb got=%b want=%b",
               {valid_m, data_m, fe_m, ov_m, busy_m}, 8'b0);
    end
  endtask

  task automatic test_basic();
    ready_i = 1'b1;
    send_frame(4'b1010, 1'b1, 1);
    tests++;
    if ({valid_l, data_l, fe_l, ov_l, busy_l} !== {1'b1, 4'b1010, 3'b000}) begin
      fails++;
      $display("FAIL basic_lsb got=%b want=%b",
               {valid_l, data_l, fe_l, ov_l, busy_l}, {1'b1, 4'b1010, 3'b000});
    end
    tests++;
    if ({valid_m, data_m, fe_m, ov_m, busy_m} !== {1'b1, 4'b0101, 3'b000}) begin
      fails++;
      $display("FAIL basic_msb got=%b want=%b",
               {valid_m, data_m, fe_m, ov_m, busy_m}, {1'b1, 4'b0101, 3'b000});
    end
    tick(1'b0, 1'b1, 1'b0);
    tests++;
    if ({valid_l, valid_m} !== 2'b00) begin
      fails++;
      $display("FAIL basic_consume got=%b want=00", {valid_l, valid_m});
    end
  endtask

  task automatic test_overrun();
    ready_i = 1'b0;
    send_frame(4'b1010, 1'b1, 1);
    tick(1'b0, 1'b1, 1'b0);
    send_frame(4'b0110, 1'b1, 1);
    tests++;
    if ({valid_l, data_l, ov_l, fe_l} !== {1'b1, 4'b1010, 2'b10}) begin
      fails++;
      $display("FAIL overrun got=%b want=%b",
               {valid_l, data_l, ov_l, fe_l}, {1'b1, 4'b1010, 2'b10});
    end
    tick(1'b0, 1'b1, 1'b0);
    tests++;
    if ({valid_l, data_l, ov_l} !== {1'b1, 4'b1010, 1'b0}) begin
      fails++;
      $display("FAIL overrun_pulse got=%b want=%b",
               {valid_l, data_l, ov_l}, {1'b1, 4'b1010, 1'b0});
    end
    ready_i = 1'b1;
    tick(1'b0, 1'b1, 1'b0);
    tests++;
    if ({valid_l, valid_m} !== {mv, mv} || mv) begin
      fails++;
      $display("FAIL overrun_drain got=%b want=00", {valid_l, valid_m});
    end
  endtask

  task automatic test_frame_err();
    ready_i = 1'b1;
    send_frame(4'b0011, 1'b0, 1);
    tests++;
    if ({fe_l, fe_m, valid_l, ov_l, busy_l} !== 5'b11000) begin
      fails++;
      $display("FAIL frame_err got=%b want=11000",
               {fe_l, fe_m, valid_l, ov_l, busy_l});
    end
    tick(1'b1, 1'b1, 1'b0);
    tests++;
    if ({fe_l, busy_l} !== 2'b00) begin
      fails++;
      $display("FAIL frame_err_pulse got=%b want=00", {fe_l, busy_l});
    end
    send_frame(4'b1100, 1'b1, 1);
    tests++;
    if ({valid_l, data_l, valid_m, data_m, fe_l} !== {mv, md_l, mv, md_m, 1'b0}) begin
      fails++;
      $display("FAIL frame_err_recover got=%b want=%b",
               {valid_l, data_l, valid_m, data_m, fe_l}, {mv, md_l, mv, md_m, 1'b0});
    end
    tick(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_mid_reset();
    ready_i = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tests++;
    if (busy_l !== 1'b1) begin
      fails++;
      $display("FAIL mid_busy got=%b want=1", busy_l);
    end
    do_reset();
    tests++;
    if ({valid_l, data_l, fe_l, ov_l, busy_l} !== 8'b0) begin
      fails++;
      $display("FAIL mid_reset got=%b want=0",
               {valid_l, data_l, fe_l, ov_l, busy_l});
    end
    send_frame(4'b1111, 1'b1, 1);
    tests++;
    if ({valid_l, data_l, valid_m, data_m} !== 10'b11111_11111) begin
      fails++;
      $display("FAIL mid_after got=%b want=1111111111",
               {valid_l, data_l, valid_m, data_m});
    end
    tick(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_slow_en();
    ready_i = 1'b1;
    send_frame(4'b1010, 1'b1, 3);
    tests++;
    if ({valid_l, data_l, valid_m, data_m, busy_l} !== {1'b1, 4'b1010, 1'b1, 4'b0101, 1'b0}) begin
      fails++;
      $display("FAIL slow_en got=%b want=%b",
               {valid_l, data_l, valid_m, data_m, busy_l},
               {1'b1, 4'b1010, 1'b1, 4'b0101, 1'b0});
    end
    tick(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b1;
    send_frame(4'b0110, 1'b1, 1);
    tests++;
    if ({valid_l, data_l, ov_l} !== {1'b1, 4'b0110, 1'b0}) begin
      fails++;
      $display("FAIL b2b_first got=%b want=%b",
               {valid_l, data_l, ov_l}, {1'b1, 4'b0110, 1'b0});
    end
    send_frame(4'b1001, 1'b1, 1);
    tests++;
    if ({valid_l, data_l, ov_l, valid_m, data_m} !== {1'b1, 4'b1001, 1'b0, 1'b1, 4'b1001}) begin
      fails++;
      $display("FAIL b2b_second got=%b want=%b",
               {valid_l, data_l, ov_l, valid_m, data_m},
               {1'b1, 4'b1001, 1'b0, 1'b1, 4'b1001});
    end
    tick(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] b;
    bit         st;
    int         per, gap;
    for (int n = 0; n < 40; n++) begin
      b       = 4'($urandom);
      st      = ($urandom_range(0, 5) != 0);
      per     = $urandom_range(1, 3);
      gap     = $urandom_range(0, 2);
      ready_i = $urandom_range(0, 1) == 1;
      send_frame(b, st, per);
      tests++;
      if ({valid_l, data_l, fe_l, ov_l, busy_l} !== {mv, md_l, m_fe, m_ov, 1'b0}) begin
        fails++;
        $display("FAIL rand_lsb n=%0d got=%b want=%b", n,
                 {valid_l, data_l, fe_l, ov_l, busy_l}, {mv, md_l, m_fe, m_ov, 1'b0});
      end
      tests++;
      if ({valid_m, data_m, fe_m, ov_m, busy_m} !== {mv, md_m, m_fe, m_ov, 1'b0}) begin
        fails++;
        $display("FAIL rand_msb n=%0d got=%b want=%b", n,
                 {valid_m, data_m, fe_m, ov_m, busy_m}, {mv, md_m, m_fe, m_ov, 1'b0});
      end
      for (int g = 0; g < gap; g++) tick(1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    reset   = 1'b1;
    en      = 1'b0;
    sd_i    = 1'b1;
    ready_i = 1'b0;
    cur_l   = '0;
    cur_m   = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_overrun();
    test_frame_err();
    test_mid_reset();
    test_slow_en();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
